// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: advances a switch-selected pattern (rotate, ping-pong, blink)
// by one step per accepted strobe and pulses o_wrap when a pattern cycle completes.
module led_pattern_ctrl #(
  parameter int unsigned NB_LEDS = 4  // must be 2 or more
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [1:0]         i_mode,
  output logic [NB_LEDS-1:0] o_led,
  output logic [1:0]         o_mode,
  output logic               o_wrap
);

  typedef enum logic [1:0] {
    ModeRotLeft  = 2'b00,
    ModeRotRight = 2'b01,
    ModePingPong = 2'b10,
    ModeBlink    = 2'b11
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  localparam logic [NB_LEDS-1:0] LedLsb = {{(NB_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] LedMsb = {1'b1, {(NB_LEDS-1){1'b0}}};
  localparam logic [NB_LEDS-1:0] LedAll = {NB_LEDS{1'b1}};

  logic [NB_LEDS-1:0] led_q, led_d;
  mode_e              mode_q, mode_d;
  dir_e               dir_q, dir_d;
  logic               wrap_q, wrap_d;

  logic  step;
  mode_e mode_in;

  assign step    = i_enable & i_valid;
  assign mode_in = mode_e'(i_mode);

  always_comb begin
    led_d  = led_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;

    if (step) begin
      if (mode_in != mode_q) begin
        // A mode change only reloads the pattern; it never counts as an advance.
        mode_d = mode_in;
        dir_d  = DirUp;
        unique case (mode_in)
          ModeRotLeft:  led_d = LedLsb;
          ModeRotRight: led_d = LedMsb;
          ModePingPong: led_d = LedLsb;
          ModeBlink:    led_d = LedAll;
          default:      led_d = LedLsb;
        endcase
      end else begin
        unique case (mode_q)
          ModeRotLeft: begin
            led_d  = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
            wrap_d = led_q[NB_LEDS-1];
          end
          ModeRotRight: begin
            led_d  = {led_q[0], led_q[NB_LEDS-1:1]};
            wrap_d = led_q[0];
          end
          ModePingPong: begin
            // Direction flips on the step that lands on an endpoint, so each end shows once.
            if (dir_q == DirUp) begin
              led_d = led_q << 1;
              if (led_d[NB_LEDS-1]) dir_d = DirDown;
            end else begin
              led_d = led_q >> 1;
              if (led_d[0]) begin
                dir_d  = DirUp;
                wrap_d = 1'b1;
              end
            end
          end
          ModeBlink: begin
            led_d  = ~led_q;
            wrap_d = (led_q == '0);
          end
          default: led_d = led_q;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      led_q  <= LedLsb;
      mode_q <= ModeRotLeft;
      dir_q  <= DirUp;
      wrap_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_led  = led_q;
  assign o_mode = mode_q;
  assign o_wrap = wrap_q;

  a_onehot_outside_blink : assert property (@(posedge clock) disable iff (!i_reset)
    (mode_q != ModeBlink) |-> $onehot(led_q));

  a_wrap_needs_step : assert property (@(posedge clock) disable iff (!i_reset)
    !step |=> !wrap_q);

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl (NB_LEDS=4): a vector table plus hand-written corner sequences,
// with expected results queued at drive time and popped after each clock edge.
module tb_led_pattern_ctrl;

  localparam int unsigned NbLeds = 4;

  logic              clock;
  logic              i_reset;
  logic              i_valid;
  logic              i_enable;
  logic [1:0]        i_mode;
  logic [NbLeds-1:0] o_led;
  logic [1:0]        o_mode;
  logic              o_wrap;

  led_pattern_ctrl #(.NB_LEDS(NbLeds)) dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .i_enable (i_enable),
    .i_mode   (i_mode),
    .o_led    (o_led),
    .o_mode   (o_mode),
    .o_wrap   (o_wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic              rst_n;
    logic              en;
    logic              val;
    logic [1:0]        mode;
    logic [NbLeds-1:0] led;
    logic [1:0]        omode;
    logic              wrap;
  } vec_t;

  typedef struct {
    logic [NbLeds-1:0] led;
    logic [1:0]        omode;
    logic              wrap;
    string             name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks;
  int   errors;

  function automatic vec_t mk(input logic rst_n, input logic en, input logic val,
                              input logic [1:0] mode, input logic [NbLeds-1:0] led,
                              input logic [1:0] omode, input logic wrap);
    vec_t v;
    v.rst_n = rst_n;
    v.en    = en;
    v.val   = val;
    v.mode  = mode;
    v.led   = led;
    v.omode = omode;
    v.wrap  = wrap;
    return v;
  endfunction

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow: got empty queue, required one entry");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (o_led !== e.led) begin
      errors++;
      $display("FAIL %s led: got %b required %b", e.name, o_led, e.led);
    end
    checks++;
    if (o_mode !== e.omode) begin
      errors++;
      $display("FAIL %s mode: got %b required %b", e.name, o_mode, e.omode);
    end
    checks++;
    if (o_wrap !== e.wrap) begin
      errors++;
      $display("FAIL %s wrap: got %b required %b", e.name, o_wrap, e.wrap);
    end
  endtask

  // Drive one cycle of inputs, queue what the next edge must produce, then compare after it.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    i_reset  = v.rst_n;
    i_enable = v.en;
    i_valid  = v.val;
    i_mode   = v.mode;
    e.led    = v.led;
    e.omode  = v.omode;
    e.wrap   = v.wrap;
    e.name   = name;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_front();
  endtask

  task automatic cyc(input logic rst_n, input logic en, input logic val, input logic [1:0] mode,
                     input logic [NbLeds-1:0] led, input logic [1:0] omode, input logic wrap,
                     input string name);
    apply(mk(rst_n, en, val, mode, led, omode, wrap), name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    i_reset  = 1'b0;
    i_enable = 1'b0;
    i_valid  = 1'b0;
    i_mode   = 2'b00;

    // Reset, rotate left, then reset and ping-pong with a reload.
    tbl.push_back(mk(0, 0, 0, 2'b00, 4'b0001, 2'b00, 0));
    tbl.push_back(mk(0, 1, 1, 2'b11, 4'b0001, 2'b00, 0));
    tbl.push_back(mk(1, 1, 1, 2'b00, 4'b0010, 2'b00, 0));
    tbl.push_back(mk(1, 1, 0, 2'b00, 4'b0010, 2'b00, 0));
    tbl.push_back(mk(1, 1, 1, 2'b00, 4'b0100, 2'b00, 0));
    tbl.push_back(mk(1, 1, 0, 2'b00, 4'b0100, 2'b00, 0));
    tbl.push_back(mk(1, 1, 1, 2'b00, 4'b1000, 2'b00, 0));
    tbl.push_back(mk(1, 1, 0, 2'b00, 4'b1000, 2'b00, 0));
    tbl.push_back(mk(1, 1, 1, 2'b00, 4'b0001, 2'b00, 1));
    tbl.push_back(mk(1, 1, 0, 2'b00, 4'b0001, 2'b00, 0));
    tbl.push_back(mk(1, 1, 1, 2'b00, 4'b0010, 2'b00, 0));
    tbl.push_back(mk(0, 1, 0, 2'b10, 4'b0001, 2'b00, 0));
    tbl.push_back(mk(1, 1, 1, 2'b10, 4'b0001, 2'b10, 0));
    tbl.push_back(mk(1, 1, 1, 2'b10, 4'b0010, 2'b10, 0));
    tbl.push_back(mk(1, 1, 1, 2'b10, 4'b0100, 2'b10, 0));
    tbl.push_back(mk(1, 1, 1, 2'b10, 4'b1000, 2'b10, 0));
    tbl.push_back(mk(1, 1, 1, 2'b10, 4'b0100, 2'b10, 0));
    tbl.push_back(mk(1, 1, 1, 2'b10, 4'b0010, 2'b10, 0));
    tbl.push_back(mk(1, 1, 1, 2'b10, 4'b0001, 2'b10, 1));
    tbl.push_back(mk(1, 1, 1, 2'b10, 4'b0010, 2'b10, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Ping-pong freeze while heading down: direction must survive the pause.
    cyc(1, 1, 1, 2'b10, 4'b0100, 2'b10, 0, "pp_up_0100");
    cyc(1, 1, 1, 2'b10, 4'b1000, 2'b10, 0, "pp_top");
    cyc(1, 1, 1, 2'b10, 4'b0100, 2'b10, 0, "pp_down_0100");
    cyc(1, 0, 1, 2'b00, 4'b0100, 2'b10, 0, "pp_frozen_a");
    cyc(1, 0, 1, 2'b01, 4'b0100, 2'b10, 0, "pp_frozen_b");
    cyc(1, 1, 1, 2'b10, 4'b0010, 2'b10, 0, "pp_resume_down");

    // Mode change mid-pattern; mode is only sampled on a step.
    cyc(0, 0, 0, 2'b00, 4'b0001, 2'b00, 0, "mc_reset");
    cyc(1, 1, 1, 2'b00, 4'b0010, 2'b00, 0, "mc_step1");
    cyc(1, 1, 1, 2'b00, 4'b0100, 2'b00, 0, "mc_step2");
    cyc(1, 1, 0, 2'b01, 4'b0100, 2'b00, 0, "mc_idle_newmode");
    cyc(1, 1, 1, 2'b01, 4'b1000, 2'b01, 0, "mc_reload_right");
    cyc(1, 1, 1, 2'b01, 4'b0100, 2'b01, 0, "mc_right_step");
    cyc(1, 1, 1, 2'b01, 4'b0010, 2'b01, 0, "mc_right_step2");
    cyc(1, 1, 1, 2'b01, 4'b0001, 2'b01, 0, "mc_right_step3");
    cyc(1, 1, 1, 2'b01, 4'b1000, 2'b01, 1, "mc_right_wrap");

    // Blink with enable gating, then reset out of blink.
    cyc(1, 1, 1, 2'b11, 4'b1111, 2'b11, 0, "bl_reload");
    cyc(1, 1, 1, 2'b11, 4'b0000, 2'b11, 0, "bl_off");
    cyc(1, 1, 1, 2'b11, 4'b1111, 2'b11, 1, "bl_on_wrap");
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 2'b11, 4'b1111, 2'b11, 0, $sformatf("bl_disabled%0d", i));
    end
    cyc(1, 1, 1, 2'b11, 4'b0000, 2'b11, 0, "bl_resume_off");
    cyc(0, 1, 1, 2'b11, 4'b0001, 2'b00, 0, "bl_reset");

    // Continuous valid in rotate left, then reset together with valid.
    cyc(1, 1, 1, 2'b00, 4'b0010, 2'b00, 0, "cv_step1");
    cyc(1, 1, 1, 2'b00, 4'b0100, 2'b00, 0, "cv_step2");
    cyc(1, 1, 1, 2'b00, 4'b1000, 2'b00, 0, "cv_step3");
    cyc(0, 1, 1, 2'b00, 4'b0001, 2'b00, 0, "cv_reset_mid");
    cyc(1, 1, 0, 2'b00, 4'b0001, 2'b00, 0, "cv_idle_after_reset");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Consumer side of the LED tick interface: takes the one-cycle valid strobe from the rate counter and advances an LED pattern by one step per strobe.
- Switch-selected pattern modes: rotate left, rotate right, ping-pong, blink.
- Sits between the tick/rate counter and the board LED pins; reports pattern-cycle completion on a wrap pulse.

Parameters:
- NB_LEDS, 4, number of LED outputs; legal range is 2 or more.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- i_reset  input  1  synchronous, active-low reset.
- i_valid  input  1  step strobe from the rate counter; each high cycle is one step.
- i_enable  input  1  1 = accept steps; 0 = freeze pattern and ignore i_valid.
- i_mode  input  2  00 rotate left, 01 rotate right, 10 ping-pong, 11 blink.
- o_led  output  NB_LEDS  registered LED drive; bit 0 = LED0.
- o_mode  output  2  registered mode currently executing.
- o_wrap  output  1  registered one-cycle pulse when a pattern cycle completes.

Behaviour:
- Reset (i_reset=0 at a clock edge): o_led = 1 (only LED0 lit), o_mode = 00, dir = up, o_wrap = 0.
- Reset has priority over every other input. Reset mid-pattern restores these values on the next edge.
- Step condition: i_enable=1 and i_valid=1 at a clock edge.
  - No step: o_led and o_mode hold, and o_wrap = 0.
  - i_valid held high for N cycles gives N steps.
- Mode sampling: i_mode is read only on a step edge. Changes between steps have no effect until the next step.
- Mode change (sampled i_mode != o_mode) is a reload step; it is not a pattern advance:
  - o_mode <= i_mode.
  - o_led reload values: 00 and 10 load 1; 01 loads 1<<(NB_LEDS-1); 11 loads all ones.
  - dir <= up.
  - o_wrap = 0.
- Same-mode step: one pattern advance, per the state machine below. Single-step latency: o_led and o_wrap update on the edge where the step is sampled.
- State machine (state = o_mode plus dir bit):
  - ROT_LEFT (00): o_led rotates one position toward MSB; MSB wraps to LSB. o_wrap=1 on the MSB->LSB step.
  - ROT_RIGHT (01): rotates toward LSB; LSB wraps to MSB. o_wrap=1 on the LSB->MSB step.
  - PING_PONG (10), one-hot bounce, each endpoint shown once per pass:
    - dir=up: shift left. On the step that reaches MSB, dir <= down.
    - dir=down: shift right. On the step that reaches LSB, dir <= up and o_wrap=1.
    - Period 2*(NB_LEDS-1) steps; for NB_LEDS=4: 0001,0010,0100,1000,0100,0010,0001.
  - BLINK (11): o_led toggles between all ones and all zeros. o_wrap=1 on the zeros->ones step.
- Invariant: outside BLINK, o_led is always one-hot.
- o_wrap never asserts in consecutive cycles unless steps occur in consecutive cycles and each completes a cycle. For NB_LEDS=2, rotate modes wrap on every other step.
- Enable low mid-pattern: state frozen exactly. Resumes from the same o_led, dir and o_mode when enable returns.
- All outputs come directly from flops; no combinational path from inputs to outputs.

Test Plan:
- Reset then rotate left, NB_LEDS=4: i_reset=0 for 2 cycles, then i_mode=00, i_enable=1, and 5 single-cycle i_valid pulses. Required o_led: 0010,0100,1000,0001,0010. o_wrap=1 only on the 4th step.
- Ping-pong: i_mode=10 from reset, 1 reload pulse plus 7 step pulses. Required o_led: 0001(reload),0010,0100,1000,0100,0010,0001,0010. o_wrap high only on the step producing the second 0001.
- Mode change mid-pattern: rotate left at o_led=0100, switch i_mode=01 between pulses, then pulse. Required: o_led=1000 (reload), o_mode=01, o_wrap=0. Next pulse gives 0100.
- Blink with enable gating:
  - i_mode=11: reload pulse gives 1111. Next pulse gives 0000, then 1111 with o_wrap=1.
  - With i_enable=0, 3 pulses leave o_led unchanged.
- Continuous valid and reset mid-operation:
  - i_valid held high 3 cycles in rotate left from 0001: o_led 0010,0100,1000 on consecutive edges.
  - Then assert i_reset=0 mid-pattern, together with i_valid=1: next edge o_led=0001, o_mode=00, o_wrap=0.
